// File: rtl/iic_slave_if.sv
// Bus-side signals of the EEPROM-emulating I2C target; the open-drain SDA pin stays a plain inout.
interface iic_slave_if;
  logic        scl;
  logic        busy;
  logic        wr_pulse;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_pulse;
  logic [15:0] rd_addr;

  modport slave  (input scl, output busy, wr_pulse, wr_addr, wr_data, rd_pulse, rd_addr);
  modport master (output scl, input busy, wr_pulse, wr_addr, wr_data, rd_pulse, rd_addr);
endinterface

// File: rtl/iic_slave.sv
// I2C target emulating a byte-addressed serial EEPROM: oversamples SCL/SDA on sys_clk and
// serves page writes, random and sequential reads from an internal register array.
module iic_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'b1010000,
  parameter bit         ADDR_16BIT = 1'b1,
  parameter int         MEM_AW     = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  iic_slave_if.slave bus,
  inout  wire        sda
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDR_H, ADDR_L, WDATA, RDATA, RACK, IGNORE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_scl_s1, r_scl_s2, r_scl_d;
  logic              r_sda_s1, r_sda_s2, r_sda_d;
  logic              w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]        r_shreg, w_shreg_nxt;
  logic [3:0]        r_bitcnt, w_bitcnt_nxt;
  logic [MEM_AW-1:0] r_ptr, w_ptr_nxt;
  logic [7:0]        r_addr_hi, w_addr_hi_nxt;
  logic              r_rw, w_rw_nxt, r_mack, w_mack_nxt;
  logic              r_sda_oe, w_sda_oe_nxt, r_busy, w_busy_nxt;
  logic              r_wr_pulse, w_wr_pulse_nxt, r_rd_pulse, w_rd_pulse_nxt;
  logic [15:0]       r_wr_addr, w_wr_addr_nxt, r_rd_addr, w_rd_addr_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;
  logic              w_mem_we, w_rx_state;
  logic [7:0]        w_rd_byte;
  logic [15:0]       w_addr_full;
  logic [7:0]        r_mem [DEPTH];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b000;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b000;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {bus.scl, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {sda, r_sda_s1, r_sda_s2};
    end
  end

  // Both lines see identical delay, so data changes during SCL low never look like start/stop.
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;

  assign sda          = r_sda_oe ? 1'b0 : 1'bz;
  assign bus.busy     = r_busy;
  assign bus.wr_pulse = r_wr_pulse;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.rd_pulse = r_rd_pulse;
  assign bus.rd_addr  = r_rd_addr;

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bitcnt_nxt   = r_bitcnt;
    w_ptr_nxt      = r_ptr;
    w_addr_hi_nxt  = r_addr_hi;
    w_rw_nxt       = r_rw;
    w_mack_nxt     = r_mack;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_wr_pulse_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_rd_pulse_nxt = 1'b0;
    w_rd_addr_nxt  = r_rd_addr;
    w_mem_we       = 1'b0;
    w_rd_byte      = r_mem[r_ptr];
    w_addr_full    = {(ADDR_16BIT ? r_addr_hi : 8'h00), r_shreg};
    w_rx_state     = r_state inside {DEV, ADDR_H, ADDR_L, WDATA};

    if (w_stop) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = DEV;
      w_bitcnt_nxt = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      if (w_rx_state && w_scl_rise && r_bitcnt < 4'd8) begin
        w_shreg_nxt  = {r_shreg[6:0], r_sda_s2};
        w_bitcnt_nxt = r_bitcnt + 4'd1;
      end
      // bitcnt 8 = byte received (ACK starts on this fall), 9 = inside the ACK clock.
      unique case (r_state)
        DEV: begin
          if (w_scl_fall && r_bitcnt == 4'd8) begin
            if (r_shreg[7:1] == DEV_ADDR) begin
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
              w_rw_nxt     = r_shreg[0];
              w_state_nxt  = DEV_ACK;
            end else begin
              w_state_nxt  = IGNORE;
            end
          end
        end
        DEV_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_shreg_nxt    = w_rd_byte;
              w_rd_pulse_nxt = 1'b1;
              w_rd_addr_nxt  = 16'(r_ptr);
              w_sda_oe_nxt   = ~w_rd_byte[7];
              w_bitcnt_nxt   = 4'd1;
              w_state_nxt    = RDATA;
            end else begin
              w_sda_oe_nxt   = 1'b0;
              w_bitcnt_nxt   = 4'd0;
              w_state_nxt    = ADDR_16BIT ? ADDR_H : ADDR_L;
            end
          end
        end
        ADDR_H, ADDR_L, WDATA: begin
          if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_sda_oe_nxt = 1'b1;
            w_bitcnt_nxt = 4'd9;
            if (r_state == ADDR_H) w_addr_hi_nxt = r_shreg;
            if (r_state == ADDR_L) w_ptr_nxt = w_addr_full[MEM_AW-1:0];
            if (r_state == WDATA) begin
              w_mem_we       = 1'b1;
              w_wr_pulse_nxt = 1'b1;
              w_wr_addr_nxt  = 16'(r_ptr);
              w_wr_data_nxt  = r_shreg;
              w_ptr_nxt      = r_ptr + MEM_AW'(1);
            end
          end else if (w_scl_fall && r_bitcnt == 4'd9) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = 4'd0;
            if (r_state == ADDR_H) w_state_nxt = ADDR_L;
            if (r_state == ADDR_L) w_state_nxt = WDATA;
          end
        end
        RDATA: begin
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_ptr_nxt    = r_ptr + MEM_AW'(1);
              w_bitcnt_nxt = 4'd0;
              w_state_nxt  = RACK;
            end else begin
              w_sda_oe_nxt = ~r_shreg[6];
              w_shreg_nxt  = {r_shreg[6:0], 1'b0};
              w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
          end
        end
        RACK: begin
          if (w_scl_rise) w_mack_nxt = r_sda_s2;
          if (w_scl_fall) begin
            if (!r_mack) begin
              w_shreg_nxt    = w_rd_byte;
              w_rd_pulse_nxt = 1'b1;
              w_rd_addr_nxt  = 16'(r_ptr);
              w_sda_oe_nxt   = ~w_rd_byte[7];
              w_bitcnt_nxt   = 4'd1;
              w_state_nxt    = RDATA;
            end else begin
              w_state_nxt    = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_ptr      <= '0;
      r_addr_hi  <= '0;
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_pulse <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_addr_hi  <= w_addr_hi_nxt;
      r_rw       <= w_rw_nxt;
      r_mack     <= w_mack_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_pulse <= w_wr_pulse_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rd_pulse <= w_rd_pulse_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_mem_we) begin
      r_mem[r_ptr] <= r_shreg;
    end
  end
endmodule

// File: tb/tb_iic_slave.sv
// Bit-banged I2C master driving iic_slave, checked against a transaction-level EEPROM model.
module tb_iic_slave;
  localparam int H = 5;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [15:0] addr; logic [7:0] data;} ev_t;
  typedef struct {logic [6:0] dev; logic [15:0] addr; logic [7:0] data; logic exp_ack;} vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic m_sda_low = 1'b0;
  wire  sda;

  iic_slave_if bus_if ();
  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  iic_slave #(.DEV_ADDR(7'b1010000), .ADDR_16BIT(1'b1), .MEM_AW(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus_if.slave),
    .sda      (sda)
  );

  always #5 sys_clk = ~sys_clk;

  int   checks = 0;
  int   errors = 0;
  ev_t  obs_wr[$];
  logic [15:0] obs_rd[$];
  int   pw_err = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;

  always @(negedge sys_clk) begin
    if (bus_if.wr_pulse) obs_wr.push_back({bus_if.wr_addr, bus_if.wr_data});
    if (bus_if.rd_pulse) obs_rd.push_back(bus_if.rd_addr);
    if ((bus_if.wr_pulse && prev_wr) || (bus_if.rd_pulse && prev_rd)) pw_err <= pw_err + 1;
    prev_wr <= bus_if.wr_pulse;
    prev_rd <= bus_if.rd_pulse;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic [7:0]  mem_m [256];
  ev_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  int          cmp_wr = 0, cmp_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [15:0] addr, input bq_t d);
    foreach (d[i]) begin
      int a;
      a = (int'(addr) + i) % 256;
      mem_m[a] = d[i];
      exp_wr.push_back({16'(a), d[i]});
    end
  endtask

  task automatic model_read(input logic [15:0] addr, input int n, output bq_t d);
    d = {};
    for (int i = 0; i < n; i++) begin
      int a;
      a = (int'(addr) + i) % 256;
      d.push_back(mem_m[a]);
      exp_rd.push_back(16'(a));
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
    check({tag, "_rd_count"}, obs_rd.size(), exp_rd.size());
    for (int i = cmp_wr; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      check({tag, "_wr_addr"}, obs_wr[i].addr, exp_wr[i].addr);
      check({tag, "_wr_data"}, obs_wr[i].data, exp_wr[i].data);
    end
    for (int i = cmp_rd; i < exp_rd.size() && i < obs_rd.size(); i++)
      check({tag, "_rd_addr"}, obs_rd[i], exp_rd[i]);
    cmp_wr = exp_wr.size();
    cmp_rd = exp_rd.size();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(H);
    bus_if.scl = 1'b1; wait_clk(2 * H);
    m_sda_low = 1'b1; wait_clk(2 * H);
    bus_if.scl = 1'b0; wait_clk(H);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(H);
    bus_if.scl = 1'b1; wait_clk(2 * H);
    m_sda_low = 1'b0;
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; wait_clk(H);
    bus_if.scl = 1'b1; wait_clk(2 * H);
    bus_if.scl = 1'b0; wait_clk(H);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; wait_clk(H);
    bus_if.scl = 1'b1; wait_clk(H);
    b = sda; wait_clk(H);
    bus_if.scl = 1'b0; wait_clk(H);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d, output logic s9);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    m_sda_low = ack; wait_clk(H);
    bus_if.scl = 1'b1; wait_clk(H);
    s9 = sda; wait_clk(H);
    bus_if.scl = 1'b0; wait_clk(H);
    m_sda_low = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] dev, input logic [15:0] addr, input bq_t d,
                          output logic [7:0] acks);
    logic a;
    acks = '0;
    i2c_start();
    write_byte({dev, 1'b0}, a); acks[0] = a;
    write_byte(addr[15:8], a);  acks[1] = a;
    write_byte(addr[7:0], a);   acks[2] = a;
    foreach (d[i]) begin
      write_byte(d[i], a);
      if (i < 5) acks[3 + i] = a;
    end
    i2c_stop();
    wait_clk(H);
  endtask

  task automatic do_read(input logic [15:0] addr, input int n, output bq_t got,
                         output logic [3:0] acks, output logic nack_sda);
    logic a;
    logic [7:0] b;
    got = {};
    nack_sda = 1'b0;
    i2c_start();
    write_byte(8'hA0, a);      acks[0] = a;
    write_byte(addr[15:8], a); acks[1] = a;
    write_byte(addr[7:0], a);  acks[2] = a;
    i2c_start();
    write_byte(8'hA1, a);      acks[3] = a;
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, b, nack_sda);
      got.push_back(b);
    end
    i2c_stop();
    wait_clk(H);
  endtask

  initial begin
    vec_t       tbl[6];
    bq_t        wd, rd, ed;
    logic [7:0] wacks;
    logic [3:0] racks;
    logic       a, s9;
    int         n;
    logic [15:0] ad;

    tbl[0] = '{7'h50, 16'h0020, 8'h5A, 1'b1};
    tbl[1] = '{7'h50, 16'h1221, 8'hFF, 1'b1};
    tbl[2] = '{7'h51, 16'h0020, 8'h00, 1'b0};
    tbl[3] = '{7'h50, 16'h00C3, 8'h00, 1'b1};
    tbl[4] = '{7'h28, 16'h0021, 8'h81, 1'b0};
    tbl[5] = '{7'h50, 16'hFF80, 8'h96, 1'b1};
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    bus_if.scl = 1'b1;
    wait_clk(4);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_wr_pulse", bus_if.wr_pulse, 1'b0);
    check("rst_rd_pulse", bus_if.rd_pulse, 1'b0);
    check("rst_wr_addr", bus_if.wr_addr, 16'h0000);
    check("rst_wr_data", bus_if.wr_data, 8'h00);
    check("rst_rd_addr", bus_if.rd_addr, 16'h0000);
    sys_rst_n = 1'b1;
    wait_clk(4 * H);

    // Single write with busy tracking
    i2c_start();
    write_byte(8'hA0, a); check("sw_ack_dev", a, 1'b1);
    check("sw_busy_high", bus_if.busy, 1'b1);
    write_byte(8'h00, a); check("sw_ack_hi", a, 1'b1);
    write_byte(8'h05, a); check("sw_ack_lo", a, 1'b1);
    write_byte(8'hA5, a); check("sw_ack_data", a, 1'b1);
    i2c_stop();
    repeat (3) @(posedge sys_clk);
    #1 check("sw_busy_after_stop", bus_if.busy, 1'b0);
    wait_clk(H);
    model_write(16'h0005, '{8'hA5});
    check("sw_wr_addr_const", exp_wr[0].addr, 16'h0005);
    compare_events("single_write");

    // Random read of the byte just written
    do_read(16'h0005, 1, rd, racks, s9);
    check("rr_acks", racks, 4'hF);
    check("rr_data", rd[0], 8'hA5);
    check("rr_nack_released", s9, 1'b1);
    model_read(16'h0005, 1, ed);
    compare_events("random_read");

    // Wrong device address
    i2c_start();
    write_byte(8'hA2, a); check("wd_no_ack", a, 1'b0);
    check("wd_busy_low", bus_if.busy, 1'b0);
    write_byte(8'h00, a); check("wd_no_ack2", a, 1'b0);
    i2c_stop();
    wait_clk(H);
    compare_events("wrong_dev");
    do_write(7'h50, 16'h0010, '{8'h3C}, wacks);
    check("wd_follow_acks", wacks, 8'h0F);
    model_write(16'h0010, '{8'h3C});
    compare_events("wrong_dev_follow");

    // Page write across the top of memory
    do_write(7'h50, 16'h00FF, '{8'h11, 8'h22}, wacks);
    check("pw_acks", wacks, 8'h1F);
    model_write(16'h00FF, '{8'h11, 8'h22});
    compare_events("page_wrap");
    do_read(16'h00FF, 2, rd, racks, s9);
    check("pw_mem_ff", rd[0], 8'h11);
    check("pw_mem_00", rd[1], 8'h22);
    model_read(16'h00FF, 2, ed);
    compare_events("page_wrap_rb");

    // Sequential read spanning the wrap
    do_read(16'h00FE, 3, rd, racks, s9);
    model_read(16'h00FE, 3, ed);
    check("sr_acks", racks, 4'hF);
    check("sr_size", rd.size(), 3);
    for (int i = 0; i < 3 && i < rd.size(); i++) check("sr_data", rd[i], ed[i]);
    check("sr_nack_released", s9, 1'b1);
    compare_events("seq_read");

    // Table of single-byte writes then readbacks
    for (int i = 0; i < 6; i++) begin
      do_write(tbl[i].dev, tbl[i].addr, '{tbl[i].data}, wacks);
      check("tbl_dev_ack", wacks[0], tbl[i].exp_ack);
      if (tbl[i].exp_ack) begin
        check("tbl_all_acks", wacks, 8'h0F);
        model_write(tbl[i].addr, '{tbl[i].data});
      end
      compare_events("tbl_write");
    end
    for (int i = 0; i < 6; i++) begin
      do_read(tbl[i].addr, 1, rd, racks, s9);
      model_read(tbl[i].addr, 1, ed);
      check("tbl_rb_data", rd[0], ed[0]);
      compare_events("tbl_read");
    end

    // Randomized transactions against the model
    for (int k = 0; k < 12; k++) begin
      ad = 16'($urandom);
      n = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        wd = {};
        for (int j = 0; j < n; j++) wd.push_back(8'($urandom));
        do_write(7'h50, ad, wd, wacks);
        check("rnd_wr_acks", wacks, 8'((1 << (3 + n)) - 1));
        model_write(ad, wd);
        compare_events("rnd_write");
      end else begin
        do_read(ad, n, rd, racks, s9);
        model_read(ad, n, ed);
        check("rnd_rd_acks", racks, 4'hF);
        for (int j = 0; j < n; j++) check("rnd_rd_data", rd[j], ed[j]);
        compare_events("rnd_read");
      end
    end

    // Reset while the slave is driving a 0
    do_write(7'h50, 16'h0040, '{8'h12, 8'h34}, wacks);
    model_write(16'h0040, '{8'h12, 8'h34});
    compare_events("pre_reset");
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h00, a);
    write_byte(8'h40, a);
    i2c_start();
    write_byte(8'hA1, a); check("mr_ack_read", a, 1'b1);
    model_read(16'h0040, 1, ed);
    check("mr_sda_driven_low", sda, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1 check("mr_sda_released", sda, 1'b1);
    check("mr_busy_cleared", bus_if.busy, 1'b0);
    wait_clk(3);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    wait_clk(2 * H);
    compare_events("mid_reset");
    do_write(7'h50, 16'h0040, '{8'h77}, wacks);
    check("mr_after_acks", wacks, 8'h0F);
    model_write(16'h0040, '{8'h77});
    do_read(16'h0040, 2, rd, racks, s9);
    model_read(16'h0040, 2, ed);
    check("mr_rb0", rd[0], ed[0]);
    check("mr_rb1_cleared", rd[1], ed[1]);
    compare_events("post_reset");

    check("pulse_width", pw_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
